// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Defaults match the 100 MHz system clock used by the CAN block.
package clkdiv_pkg;

  localparam int unsigned CntWDef   = 27;
  localparam int unsigned DefDivDef = 50;
  localparam int unsigned MaxNumCh  = 16;

  // Channel index width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Divisor write bus of multi_clock_divider: strobe, channel select and value.
// The master drives a one-cycle div_wr; the divider samples it as slave.
interface multi_clock_divider_if
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CntWDef
);

  localparam int unsigned ChW = ch_idx_w(NUM_CH);

  logic             div_wr;
  logic [ChW-1:0]   div_ch;
  logic [CNT_W-1:0] div_val;

  modport master (
    output div_wr,
    output div_ch,
    output div_val
  );

  modport slave (
    input div_wr,
    input div_ch,
    input div_val
  );

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor and registered outputs.
// Phase restart via sync_i is only exercised when the top has CLKDIV_SYNC_EN.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CntW   = CntWDef,
  parameter int unsigned DefDiv = DefDivDef
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            sync_i,
  input  logic            wr_i,
  input  logic [CntW-1:0] wr_val_i,
  output logic            slow_clk_o,
  output logic            tick_o,
  output logic            upd_pend_o
);

  localparam logic [CntW-1:0] DefDivV = CntW'(DefDiv);
  localparam logic [CntW-1:0] One     = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] div_q, div_d;
  logic [CntW-1:0] shadow_q, shadow_d;
  logic            slow_q, slow_d;
  logic            tick_q, tick_d;
  logic            pend_q, pend_d;

  logic run;
  logic terminal;

  // A zero divisor halts the channel exactly like a dropped enable.
  assign run      = en_i && (div_q != '0);
  assign terminal = run && (cnt_q == (div_q - One));

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    slow_d   = slow_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;

    if (terminal) begin
      cnt_d  = '0;
      slow_d = ~slow_q;
      tick_d = 1'b1;
    end else if (run) begin
      cnt_d = cnt_q + One;
    end

    if (sync_i) begin
      // Restart wins over the terminal edge; a pending divisor still lands.
      cnt_d  = '0;
      slow_d = 1'b0;
      tick_d = 1'b0;
      if (pend_q) begin
        div_d = shadow_q;
      end
      pend_d = 1'b0;
      if (wr_i) begin
        shadow_d = wr_val_i;
        pend_d   = 1'b1;
      end
    end else if (wr_i && terminal) begin
      div_d    = wr_val_i;
      shadow_d = wr_val_i;
      pend_d   = 1'b0;
    end else if (wr_i) begin
      shadow_d = wr_val_i;
      pend_d   = 1'b1;
    end else if (pend_q && (terminal || !run)) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      div_q    <= DefDivV;
      shadow_q <= DefDivV;
      slow_q   <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      slow_q   <= slow_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign slow_clk_o = slow_q;
  assign tick_o     = tick_q;
  assign upd_pend_o = pend_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable 50 % duty clock divider with shadowed divisors.
// Define CLKDIV_SYNC_EN to add the sync port that restarts all channel phases.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = CntWDef,
  parameter int unsigned DEF_DIV = DefDivDef
) (
  input  logic                 clk100Mhz,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    en,
`ifdef CLKDIV_SYNC_EN
  input  logic                 sync,
`endif
  multi_clock_divider_if.slave div_bus,
  output logic [NUM_CH-1:0]    slow_clk,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    upd_pend
);

  localparam int unsigned ChW = ch_idx_w(NUM_CH);

  logic              sync_all;
  logic [ChW-1:0]    ch_sel;
  logic [NUM_CH-1:0] wr_en;

`ifdef CLKDIV_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  assign ch_sel = div_bus.div_ch;

  // Select values at or above NUM_CH match no channel and are dropped.
  always_comb begin
    wr_en = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (div_bus.div_wr && (ch_sel == ChW'(k))) begin
        wr_en[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CntW   (CNT_W),
      .DefDiv (DEF_DIV)
    ) u_ch (
      .clk_i      (clk100Mhz),
      .rst_ni     (rst_n),
      .en_i       (en[g]),
      .sync_i     (sync_all),
      .wr_i       (wr_en[g]),
      .wr_val_i   (div_bus.div_val),
      .slow_clk_o (slow_clk[g]),
      .tick_o     (tick[g]),
      .upd_pend_o (upd_pend[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: expected tick edges are queued per
// channel when stimulus is applied and popped as the DUT ticks.
module tb_multi_clock_divider;

  localparam int NCH = 4;
  localparam int CW  = 27;

  typedef struct {
    int   cyc;
    logic lvl;
  } ev_t;

  logic           clk100Mhz;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic [NCH-1:0] slow_clk;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] upd_pend;
`ifdef CLKDIV_SYNC_EN
  logic           sync;
`endif

  multi_clock_divider_if #(.NUM_CH(NCH), .CNT_W(CW)) div_bus ();

  multi_clock_divider #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .DEF_DIV (50)
  ) dut (
    .clk100Mhz (clk100Mhz),
    .rst_n     (rst_n),
    .en        (en),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .div_bus   (div_bus),
    .slow_clk  (slow_clk),
    .tick      (tick),
    .upd_pend  (upd_pend)
  );

  initial clk100Mhz = 1'b0;
  always #5 clk100Mhz = ~clk100Mhz;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  logic [NCH-1:0] prev  = '0;
  ev_t            exp_q[NCH][$];

  task automatic step();
    @(posedge clk100Mhz);
    cyc++;
    @(negedge clk100Mhz);
  endtask

  task automatic push_ev(input int c, input int cy, input logic lvl);
    exp_q[c].push_back('{cyc: cy, lvl: lvl});
  endtask

  task automatic write_div(input int c, input int v);
    div_bus.div_wr  = 1'b1;
    div_bus.div_ch  = 2'(c);
    div_bus.div_val = CW'(v);
  endtask

  // Releases reset on a falling edge; edge 1 is the first rising edge after.
  task automatic do_reset(input logic [NCH-1:0] en_val);
    @(negedge clk100Mhz);
    rst_n          = 1'b0;
    en             = '0;
    div_bus.div_wr = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync           = 1'b0;
`endif
    repeat (2) @(negedge clk100Mhz);
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    rst_n = 1'b1;
    en    = en_val;
    cyc   = 0;
    prev  = '0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    en              = '0;
    div_bus.div_wr  = 1'b0;
    div_bus.div_ch  = '0;
    div_bus.div_val = '0;
`ifdef CLKDIV_SYNC_EN
    sync            = 1'b0;
`endif
    #23;
    en = '1;
    repeat (3) @(negedge clk100Mhz);
    total++;
    if (slow_clk !== 4'b0000) begin
      bad++;
      $display("FAIL reset_slow_clk: got %b, required 0000", slow_clk);
    end
    total++;
    if (tick !== 4'b0000) begin
      bad++;
      $display("FAIL reset_tick: got %b, required 0000", tick);
    end
    total++;
    if (upd_pend !== 4'b0000) begin
      bad++;
      $display("FAIL reset_upd_pend: got %b, required 0000", upd_pend);
    end
  endtask

  task automatic test_default();
    ev_t ev;
    do_reset(4'b1111);
    for (int c = 0; c < NCH; c++) begin
      for (int k = 1; k <= 5; k++) push_ev(c, 50 * k, logic'(k % 2));
    end
    for (int n = 0; n < 250; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL default_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL default_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c]) begin
          total++;
          bad++;
          $display("FAIL default_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL default_missing ch%0d: %0d ticks not seen, required 0 left", c,
                 exp_q[c].size());
      end
    end
  endtask

  task automatic test_div_extremes();
    ev_t ev;
    do_reset(4'b0000);
    write_div(0, 1);
    for (int k = 4; k <= 23; k++) push_ev(0, k, logic'((k - 3) % 2));
    for (int n = 0; n < 23; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL extreme_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL extreme_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c]) begin
          total++;
          bad++;
          $display("FAIL extreme_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
      if (cyc == 1) begin
        total++;
        if (upd_pend !== 4'b0001) begin
          bad++;
          $display("FAIL extreme_pend_set: got %b, required 0001", upd_pend);
        end
        write_div(1, 0);
      end else if (cyc == 2) begin
        div_bus.div_wr = 1'b0;
      end else if (cyc == 3) begin
        total++;
        if (upd_pend !== 4'b0000) begin
          bad++;
          $display("FAIL extreme_pend_idle_xfer: got %b, required 0000", upd_pend);
        end
        en = 4'b0011;
      end
    end
    total++;
    if (slow_clk[1] !== 1'b0 || tick[1] !== 1'b0) begin
      bad++;
      $display("FAIL extreme_halt ch1: got slow %b tick %b, required 0 0", slow_clk[1], tick[1]);
    end
    total++;
    if (exp_q[0].size() != 0) begin
      bad++;
      $display("FAIL extreme_missing ch0: %0d ticks not seen, required 0 left", exp_q[0].size());
    end
  endtask

  task automatic test_shadow_update();
    ev_t ev;
    do_reset(4'b1111);
    push_ev(0, 50, 1'b1);
    push_ev(1, 50, 1'b1);
    push_ev(3, 50, 1'b1);
    push_ev(2, 50, 1'b1);
    push_ev(2, 60, 1'b0);
    push_ev(2, 70, 1'b1);
    push_ev(2, 80, 1'b0);
    for (int n = 0; n < 80; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL shadow_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL shadow_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c]) begin
          total++;
          bad++;
          $display("FAIL shadow_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
      if (cyc == 20) write_div(2, 10);
      if (cyc == 21) div_bus.div_wr = 1'b0;
      if (cyc == 21 || cyc == 49) begin
        total++;
        if (upd_pend !== 4'b0100) begin
          bad++;
          $display("FAIL shadow_pend cyc%0d: got %b, required 0100", cyc, upd_pend);
        end
      end
      if (cyc == 50) begin
        total++;
        if (upd_pend !== 4'b0000) begin
          bad++;
          $display("FAIL shadow_pend_clear: got %b, required 0000", upd_pend);
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL shadow_missing ch%0d: %0d ticks not seen, required 0 left", c,
                 exp_q[c].size());
      end
    end
  endtask

  task automatic test_write_through();
    ev_t  ev;
    logic pend_seen;
    pend_seen = 1'b0;
    do_reset(4'b1111);
    for (int c = 0; c < 3; c++) push_ev(c, 50, 1'b1);
    push_ev(3, 50, 1'b1);
    push_ev(3, 57, 1'b0);
    push_ev(3, 64, 1'b1);
    push_ev(3, 71, 1'b0);
    for (int n = 0; n < 75; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL wthru_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL wthru_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c]) begin
          total++;
          bad++;
          $display("FAIL wthru_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
      pend_seen = pend_seen | upd_pend[3];
      if (cyc == 49) write_div(3, 7);
      if (cyc == 50) div_bus.div_wr = 1'b0;
    end
    total++;
    if (pend_seen !== 1'b0) begin
      bad++;
      $display("FAIL wthru_pend ch3: got upd_pend seen %b, required 0", pend_seen);
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL wthru_missing ch%0d: %0d ticks not seen, required 0 left", c,
                 exp_q[c].size());
      end
    end
  endtask

  task automatic test_enable_freeze();
    ev_t ev;
    do_reset(4'b1111);
    for (int c = 0; c < NCH; c++) begin
      if (c == 1) begin
        push_ev(c, 90, 1'b1);
      end else begin
        push_ev(c, 50, 1'b1);
        push_ev(c, 100, 1'b0);
      end
    end
    for (int n = 0; n < 100; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL freeze_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL freeze_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c]) begin
          total++;
          bad++;
          $display("FAIL freeze_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
      if (cyc == 30) en = 4'b1101;
      if (cyc == 70) begin
        total++;
        if (slow_clk !== 4'b1101) begin
          bad++;
          $display("FAIL freeze_level: got %b, required 1101", slow_clk);
        end
        en = 4'b1111;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL freeze_missing ch%0d: %0d ticks not seen, required 0 left", c,
                 exp_q[c].size());
      end
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    ev_t ev;
    do_reset(4'b0011);
    push_ev(0, 50, 1'b1);
    push_ev(0, 81, 1'b1);
    push_ev(0, 101, 1'b0);
    push_ev(0, 121, 1'b1);
    push_ev(0, 141, 1'b0);
    push_ev(1, 50, 1'b1);
    push_ev(1, 111, 1'b1);
    push_ev(1, 141, 1'b0);
    push_ev(2, 111, 1'b1);
    push_ev(3, 111, 1'b1);
    for (int n = 0; n < 145; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL sync_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL sync_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c] && cyc != 61) begin
          total++;
          bad++;
          $display("FAIL sync_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
      if (cyc == 25) en = 4'b1111;
      if (cyc == 40) write_div(0, 20);
      if (cyc == 41) begin
        div_bus.div_wr = 1'b0;
        total++;
        if (upd_pend !== 4'b0001) begin
          bad++;
          $display("FAIL sync_pre_pend: got %b, required 0001", upd_pend);
        end
      end
      if (cyc == 60) begin
        sync = 1'b1;
        write_div(1, 30);
      end
      if (cyc == 61) begin
        sync           = 1'b0;
        div_bus.div_wr = 1'b0;
        total++;
        if (slow_clk !== 4'b0000 || tick !== 4'b0000) begin
          bad++;
          $display("FAIL sync_restart: got slow %b tick %b, required 0000 0000", slow_clk, tick);
        end
        total++;
        if (upd_pend !== 4'b0010) begin
          bad++;
          $display("FAIL sync_pend: got %b, required 0010", upd_pend);
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL sync_missing ch%0d: %0d ticks not seen, required 0 left", c,
                 exp_q[c].size());
      end
    end
  endtask
`endif

  task automatic test_reset_midperiod();
    ev_t ev;
    do_reset(4'b1111);
    for (int n = 0; n < 55; n++) begin
      step();
      if (cyc == 54) write_div(2, 5);
    end
    div_bus.div_wr = 1'b0;
    total++;
    if (slow_clk !== 4'b1111 || upd_pend !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_pre: got slow %b pend %b, required 1111 0100", slow_clk, upd_pend);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (slow_clk !== 4'b0000 || tick !== 4'b0000 || upd_pend !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_async: got slow %b tick %b pend %b, required all 0", slow_clk, tick,
               upd_pend);
    end
    do_reset(4'b1111);
    for (int c = 0; c < NCH; c++) begin
      push_ev(c, 50, 1'b1);
      push_ev(c, 100, 1'b0);
    end
    for (int n = 0; n < 100; n++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL midrst_tick ch%0d: tick at cyc %0d, required none", c, cyc);
          end else begin
            ev = exp_q[c].pop_front();
            if (ev.cyc != cyc || ev.lvl !== slow_clk[c]) begin
              bad++;
              $display("FAIL midrst_tick ch%0d: got cyc %0d lvl %b, required cyc %0d lvl %b",
                       c, cyc, slow_clk[c], ev.cyc, ev.lvl);
            end
          end
        end else if (slow_clk[c] !== prev[c]) begin
          total++;
          bad++;
          $display("FAIL midrst_edge ch%0d: slow_clk moved at cyc %0d without tick, required hold",
                   c, cyc);
        end
      end
      prev = slow_clk;
    end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL midrst_missing ch%0d: %0d ticks not seen, required 0 left", c,
                 exp_q[c].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_div_extremes();
    test_shadow_update();
    test_write_through();
    test_enable_freeze();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    test_reset_midperiod();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised N-channel programmable clock divider for the CAN module: each channel derives a 50 %-duty slow clock and a one-cycle tick strobe from the 100 MHz system clock. It generalises the single-channel divider with per-channel enables, a runtime-writable shadowed divisor with glitch-free update at period boundaries, a defined divisor-0 halt mode and an optional phase-sync input. Consumers are the CAN bit-timing logic, the sample-point generator and slow housekeeping timers.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 27: divisor and counter width.
- DEF_DIV, 50: reset divisor for every channel (half-period in input cycles).

Ports:
- clk100Mhz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  NUM_CH  per-channel run enable.
- div_wr  in  1  one-cycle divisor write strobe.
- div_ch  in  $clog2(NUM_CH) (min 1)  target channel of div_wr.
- div_val  in  CNT_W  new divisor (half-period, input cycles).
- sync  in  1  phase restart of all channels (present only with CLKDIV_SYNC_EN).
- slow_clk  out  NUM_CH  divided clocks (registered).
- tick  out  NUM_CH  one-cycle pulse on every slow_clk edge (registered).
- upd_pend  out  NUM_CH  shadow divisor written, not yet active.

## Operation
- Per channel: active divisor D, shadow S, counter C (0..D-1), slow_clk, tick, upd_pend.
- Reset: C=0, slow_clk=0, tick=0, D=S=DEF_DIV, upd_pend=0.
- Running (en=1, D≠0): C increments each cycle; at C==D-1 (terminal): C←0, slow_clk toggles, tick=1 for that cycle. Output period = 2·D cycles, duty exactly 50 %. D=1 → clk/2.
- D=0: halt — C held at 0, slow_clk holds its level, tick=0.
- en=0: C and slow_clk freeze, tick=0; en returning high resumes from the frozen count.
- Divisor write (div_wr, div_ch=k, div_val=V): S_k←V, upd_pend_k←1. Out-of-range div_ch ignored.
- Transfer S→D at the channel's next terminal cycle, or on the next cycle if the channel is idle (en=0 or D=0); upd_pend clears on transfer.
- Write coincident with terminal cycle on the same channel: V loads directly into D (write-through), upd_pend stays 0.
- Second write before transfer: overwrites S; only the last value is used.
- sync (if compiled): all channels C←0, slow_clk←0, tick←0, pending S→D applied; sync overrides terminal and write-through on that cycle; a same-cycle div_wr still lands in S.
- Reset mid-period: everything returns to reset values asynchronously; no tick on release.

## Timing
- All outputs registered; tick and slow_clk change on the same edge.
- After rst_n release with en=1: first slow_clk rise and tick at the D-th rising edge.
- div_wr at edge t → upd_pend=1 from t+1; new D effective for the period starting after the next terminal.
- sync at edge t: slow_clk=0 from t+1; first rise D edges after t.
- No combinational path from any input to any output.

## Configuration
- CLKDIV_SYNC_EN defined: sync port and phase-restart logic present.
- Undefined: no sync port; channels only realign via reset; all other behaviour identical.

## Structure
- Package clkdiv_pkg: CNT_W default, DEF_DIV default, NUM_CH maximum, channel-index width function.
- Sub-module clkdiv_channel: one counter/shadow/output set; top decodes div_ch to per-channel write enables and fans out sync.

## Test plan
- Reset, en=4'b1111, DEF_DIV=50 → each slow_clk period 100 cycles, first rise at edge 50, one tick per edge.
- Ch0 D=1 → slow_clk toggles every cycle, tick held high continuously; ch1 D=0 → slow_clk static, tick 0.
- Write V=10 to ch2 mid-period (C=20, D=50) → upd_pend=1; current half-period completes at 50, next half-periods 10 cycles; upd_pend clears on the terminal.
- Write V=7 to ch3 exactly on its terminal cycle → next half-period 7 cycles, upd_pend never set.
- en_1 dropped at C=30 for 40 cycles → slow_clk and C frozen, no ticks; edge occurs 20 cycles after re-enable.
- (CLKDIV_SYNC_EN) channels at different phases, pulse sync → all slow_clk=0 next cycle, rises aligned D edges later; rst_n asserted mid-period → outputs 0 immediately.
